// File: rtl/axil_resp_pkg.sv
// Shared widths, channel state encodings and the byte-strobe merge helper
// for the AXI-Lite register responder.
package axil_resp_pkg;

   localparam int AXIL_DATA_W = 32;
   localparam int AXIL_STRB_W = 4;

   typedef enum logic {
      AW_EMPTY = 1'b0,
      AW_HELD  = 1'b1
   } aw_state_e;

   typedef enum logic {
      W_EMPTY = 1'b0,
      W_HELD  = 1'b1
   } w_state_e;

   function automatic logic [AXIL_DATA_W-1:0] strb_merge(
      input logic [AXIL_DATA_W-1:0] old_v,
      input logic [AXIL_DATA_W-1:0] wdata,
      input logic [AXIL_STRB_W-1:0] wstrb
   );
      logic [AXIL_DATA_W-1:0] res;
      for (int b = 0; b < AXIL_STRB_W; b++) begin
         res[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axil_reg_responder_if.sv
// Reduced AXI-Lite channel bundle (no BRESP/RRESP) between an SoC master and a
// register responder.
interface axil_reg_responder_if;
   import axil_resp_pkg::*;

   logic [31:0]            s_axi_awaddr;
   logic [2:0]             s_axi_awprot;
   logic                   s_axi_awvalid;
   logic                   s_axi_awready;
   logic [AXIL_DATA_W-1:0] s_axi_wdata;
   logic [AXIL_STRB_W-1:0] s_axi_wstrb;
   logic                   s_axi_wvalid;
   logic                   s_axi_wready;
   logic                   s_axi_bvalid;
   logic                   s_axi_bready;
   logic [31:0]            s_axi_araddr;
   logic [2:0]             s_axi_arprot;
   logic                   s_axi_arvalid;
   logic                   s_axi_arready;
   logic                   s_axi_rvalid;
   logic                   s_axi_rready;
   logic [AXIL_DATA_W-1:0] s_axi_rdata;

   modport master (
      output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
      output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      output s_axi_bready,
      output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
      output s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bvalid,
      input  s_axi_arready, s_axi_rvalid, s_axi_rdata
   );

   modport slave (
      input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      input  s_axi_bready,
      input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
      input  s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bvalid,
      output s_axi_arready, s_axi_rvalid, s_axi_rdata
   );

endinterface

// File: rtl/axil_reg_responder_reg_bank.sv
// Register storage with byte-strobed writes, a one-cycle commit pulse per
// register and a combinational read mux.
module axil_reg_bank
   import axil_resp_pkg::*;
#(
   parameter int NREGS = 8,
   parameter int IDX_W = $clog2(NREGS)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_wr_en,
   input  logic [IDX_W-1:0]             i_wr_idx,
   input  logic [AXIL_DATA_W-1:0]       i_wdata,
   input  logic [AXIL_STRB_W-1:0]       i_wstrb,
   input  logic                         i_rd_en,
   input  logic [IDX_W-1:0]             i_rd_idx,
   output logic [AXIL_DATA_W-1:0]       o_rd_data,
   output logic [NREGS*AXIL_DATA_W-1:0] o_reg_q,
   output logic [NREGS-1:0]             o_reg_wr
);

   logic [AXIL_DATA_W-1:0] r_regs [NREGS];
   logic [NREGS-1:0]       r_reg_wr;

   // storage update and commit pulse
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_reg_wr <= '0;
      end else begin
         r_reg_wr <= '0;
         if (i_wr_en) begin
            r_regs[i_wr_idx]   <= strb_merge(r_regs[i_wr_idx], i_wdata, i_wstrb);
            r_reg_wr[i_wr_idx] <= 1'b1;
         end
      end
   end

   // out-of-range reads see zero
   always_comb begin
      o_rd_data = '0;
      if (i_rd_en) begin
         o_rd_data = r_regs[i_rd_idx];
      end else begin
         o_rd_data = '0;
      end
   end

   always_comb begin
      o_reg_q = '0;
      for (int i = 0; i < NREGS; i++) begin
         o_reg_q[i*AXIL_DATA_W +: AXIL_DATA_W] = r_regs[i];
      end
   end

   assign o_reg_wr = r_reg_wr;

endmodule

// File: rtl/axil_reg_responder.sv
// AXI-Lite register responder: independent AW/W holding FSMs, B and R response
// registers, in front of an axil_reg_bank.
module axil_reg_responder
   import axil_resp_pkg::*;
#(
   parameter int NREGS  = 8,
   parameter int OFFS_W = 12
) (
   input  logic                         aclk,
   input  logic                         areset,
   axil_reg_responder_if.slave          s_axi,
   output logic [NREGS*AXIL_DATA_W-1:0] reg_q,
   output logic [NREGS-1:0]             reg_wr
);

   localparam int IDX_W = $clog2(NREGS);

   aw_state_e              r_aw_st;
   aw_state_e              w_aw_st_nxt;
   w_state_e               r_w_st;
   w_state_e               w_w_st_nxt;
   logic [OFFS_W-1:0]      r_awoffs;
   logic [AXIL_DATA_W-1:0] r_wdata;
   logic [AXIL_STRB_W-1:0] r_wstrb;
   logic                   r_bvalid;
   logic                   r_rvalid;
   logic [AXIL_DATA_W-1:0] r_rdata;
   logic                   w_aw_hs;
   logic                   w_w_hs;
   logic                   w_b_hs;
   logic                   w_ar_hs;
   logic                   w_r_hs;
   logic                   w_commit;
   logic                   w_wr_in_range;
   logic                   w_rd_in_range;
   logic [OFFS_W-1:0]      w_aroffs;
   logic [AXIL_DATA_W-1:0] w_rd_data;
   logic                   w_unused;

   // both channel FSMs stay HELD while bvalid is up, so no AW/W is taken then
   assign s_axi.s_axi_awready = (r_aw_st == AW_EMPTY);
   assign s_axi.s_axi_wready  = (r_w_st == W_EMPTY);
   assign s_axi.s_axi_arready = ~r_rvalid;
   assign s_axi.s_axi_bvalid  = r_bvalid;
   assign s_axi.s_axi_rvalid  = r_rvalid;
   assign s_axi.s_axi_rdata   = r_rdata;

   assign w_aw_hs  = s_axi.s_axi_awvalid & s_axi.s_axi_awready;
   assign w_w_hs   = s_axi.s_axi_wvalid & s_axi.s_axi_wready;
   assign w_b_hs   = r_bvalid & s_axi.s_axi_bready;
   assign w_ar_hs  = s_axi.s_axi_arvalid & s_axi.s_axi_arready;
   assign w_r_hs   = r_rvalid & s_axi.s_axi_rready;
   assign w_commit = (r_aw_st == AW_HELD) & (r_w_st == W_HELD) & ~r_bvalid;

   assign w_aroffs      = s_axi.s_axi_araddr[OFFS_W-1:0];
   assign w_wr_in_range = (r_awoffs[OFFS_W-1:IDX_W+2] == '0);
   assign w_rd_in_range = (w_aroffs[OFFS_W-1:IDX_W+2] == '0);

   assign w_unused = ^{s_axi.s_axi_awaddr[31:OFFS_W], s_axi.s_axi_awprot,
                       s_axi.s_axi_araddr[31:OFFS_W], s_axi.s_axi_arprot,
                       w_aroffs[1:0], r_awoffs[1:0]};

   // channel state register
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_aw_st <= AW_EMPTY;
         r_w_st  <= W_EMPTY;
      end else begin
         r_aw_st <= w_aw_st_nxt;
         r_w_st  <= w_w_st_nxt;
      end
   end

   // AW/W next state: fill on handshake, drain on the B handshake
   always_comb begin
      w_aw_st_nxt = r_aw_st;
      w_w_st_nxt  = r_w_st;
      case (r_aw_st)
         AW_EMPTY: if (w_aw_hs) w_aw_st_nxt = AW_HELD;  else w_aw_st_nxt = AW_EMPTY;
         AW_HELD:  if (w_b_hs)  w_aw_st_nxt = AW_EMPTY; else w_aw_st_nxt = AW_HELD;
         default:  w_aw_st_nxt = AW_EMPTY;
      endcase
      case (r_w_st)
         W_EMPTY: if (w_w_hs) w_w_st_nxt = W_HELD;  else w_w_st_nxt = W_EMPTY;
         W_HELD:  if (w_b_hs) w_w_st_nxt = W_EMPTY; else w_w_st_nxt = W_HELD;
         default: w_w_st_nxt = W_EMPTY;
      endcase
   end

   // request latches and response registers
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_awoffs <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_bvalid <= 1'b0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         if (w_aw_hs) r_awoffs <= s_axi.s_axi_awaddr[OFFS_W-1:0];
         if (w_w_hs) begin
            r_wdata <= s_axi.s_axi_wdata;
            r_wstrb <= s_axi.s_axi_wstrb;
         end
         if (w_commit)    r_bvalid <= 1'b1;
         else if (w_b_hs) r_bvalid <= 1'b0;
         // rdata samples the bank before any same-edge commit lands
         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
         end else if (w_r_hs) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   axil_reg_bank #(
      .NREGS (NREGS),
      .IDX_W (IDX_W)
   ) u_bank (
      .i_clk     (aclk),
      .i_rst     (areset),
      .i_wr_en   (w_commit & w_wr_in_range),
      .i_wr_idx  (r_awoffs[IDX_W+1:2]),
      .i_wdata   (r_wdata),
      .i_wstrb   (r_wstrb),
      .i_rd_en   (w_rd_in_range),
      .i_rd_idx  (w_aroffs[IDX_W+1:2]),
      .o_rd_data (w_rd_data),
      .o_reg_q   (reg_q),
      .o_reg_wr  (reg_wr)
   );

endmodule

// File: tb/tb_axil_reg_responder.sv
// Directed bench for axil_reg_responder: a vector table of writes and reads plus
// hand-built sequences for channel ordering, backpressure, collisions and reset.
module tb_axil_reg_responder;

   logic         aclk;
   logic         areset;
   logic [255:0] reg_q;
   logic [7:0]   reg_wr;
   int           n_checks = 0;
   int           n_errors = 0;

   axil_reg_responder_if bif ();

   axil_reg_responder #(
      .NREGS  (8),
      .OFFS_W (12)
   ) dut (
      .aclk   (aclk),
      .areset (areset),
      .s_axi  (bif),
      .reg_q  (reg_q),
      .reg_wr (reg_wr)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
      logic [7:0]  exp_wr;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input logic [7:0] exp_wr);
      bit         aw_done = 1'b0;
      bit         w_done  = 1'b0;
      bit         b_done  = 1'b0;
      bit         bad_rdy = 1'b0;
      int         cyc     = 0;
      int         hs_cyc  = -1;
      int         b_cyc   = -1;
      int         n_commit = 0;
      logic [7:0] wr_seen = '0;
      bif.s_axi_awaddr = addr;
      bif.s_axi_wdata  = data;
      bif.s_axi_wstrb  = strb;
      while (!b_done && cyc < 40) begin
         bif.s_axi_awvalid = !aw_done && (cyc >= aw_dly);
         bif.s_axi_wvalid  = !w_done && (cyc >= w_dly);
         bif.s_axi_bready  = (cyc >= b_dly);
         @(negedge aclk);
         if ((aw_done && bif.s_axi_awready) || (w_done && bif.s_axi_wready)) bad_rdy = 1'b1;
         if (bif.s_axi_bvalid && b_cyc < 0) b_cyc = cyc;
         if (reg_wr != 8'h00) begin
            n_commit++;
            wr_seen |= reg_wr;
         end
         if (bif.s_axi_awvalid && bif.s_axi_awready) aw_done = 1'b1;
         if (bif.s_axi_wvalid && bif.s_axi_wready) w_done = 1'b1;
         if (aw_done && w_done && hs_cyc < 0) hs_cyc = cyc;
         if (bif.s_axi_bvalid && bif.s_axi_bready) b_done = 1'b1;
         @(posedge aclk);
         #1;
         cyc++;
      end
      bif.s_axi_awvalid = 1'b0;
      bif.s_axi_wvalid  = 1'b0;
      bif.s_axi_bready  = 1'b0;
      check($sformatf("wr_done@%h", addr), 32'(b_done), 32'd1);
      check($sformatf("wr_b_lat@%h", addr), 32'(b_cyc), 32'(hs_cyc + 2));
      check($sformatf("wr_reg_wr@%h", addr), 32'(wr_seen), 32'(exp_wr));
      check($sformatf("wr_commits@%h", addr), 32'(n_commit), (exp_wr != 8'h00) ? 32'd1 : 32'd0);
      check($sformatf("wr_rdy_low@%h", addr), 32'(bad_rdy), 32'd0);
      check($sformatf("wr_rdy_back@%h", addr), {30'd0, bif.s_axi_awready, bif.s_axi_wready}, 32'd3);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] data);
      bit ar_done = 1'b0;
      bit r_done  = 1'b0;
      bit bad_rdy = 1'b0;
      int cyc     = 0;
      int hs_cyc  = -1;
      int rv_cyc  = -1;
      data = 32'hxxxxxxxx;
      bif.s_axi_araddr = addr;
      while (!r_done && cyc < 40) begin
         bif.s_axi_arvalid = !ar_done && (cyc >= ar_dly);
         bif.s_axi_rready  = (cyc >= r_dly);
         @(negedge aclk);
         if (bif.s_axi_arready === bif.s_axi_rvalid) bad_rdy = 1'b1;
         if (bif.s_axi_rvalid && rv_cyc < 0) rv_cyc = cyc;
         if (bif.s_axi_rvalid && bif.s_axi_rready) begin
            r_done = 1'b1;
            data   = bif.s_axi_rdata;
         end
         if (bif.s_axi_arvalid && bif.s_axi_arready) begin
            ar_done = 1'b1;
            hs_cyc  = cyc;
         end
         @(posedge aclk);
         #1;
         cyc++;
      end
      bif.s_axi_arvalid = 1'b0;
      bif.s_axi_rready  = 1'b0;
      check($sformatf("rd_done@%h", addr), 32'(r_done), 32'd1);
      check($sformatf("rd_lat@%h", addr), 32'(rv_cyc), 32'(hs_cyc + 1));
      check($sformatf("rd_arready@%h", addr), 32'(bad_rdy), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      int          idx;

      areset = 1'b1;
      bif.s_axi_awaddr = '0; bif.s_axi_awprot = 3'd0; bif.s_axi_awvalid = 1'b0;
      bif.s_axi_wdata = '0; bif.s_axi_wstrb = 4'h0; bif.s_axi_wvalid = 1'b0;
      bif.s_axi_bready = 1'b0;
      bif.s_axi_araddr = '0; bif.s_axi_arprot = 3'd0; bif.s_axi_arvalid = 1'b0;
      bif.s_axi_rready = 1'b0;

      // is_wr, addr, data, strb, expected rdata / register value, expected reg_wr
      for (int a = 0; a < 8; a++) tbl.push_back('{1'b0, 32'(a * 4), 32'h0, 4'h0, 32'h0, 8'h00});
      tbl.push_back('{1'b1, 32'h004, 32'h11223344, 4'hF, 32'h11223344, 8'h02});
      tbl.push_back('{1'b1, 32'h004, 32'hA5A50102, 4'h5, 32'h11A53302, 8'h02});
      tbl.push_back('{1'b0, 32'h004, 32'h0,        4'h0, 32'h11A53302, 8'h00});
      tbl.push_back('{1'b1, 32'h000, 32'h12345678, 4'hF, 32'h12345678, 8'h01});
      tbl.push_back('{1'b0, 32'h020, 32'h0,        4'h0, 32'h00000000, 8'h00});
      tbl.push_back('{1'b0, 32'h820, 32'h0,        4'h0, 32'h00000000, 8'h00});
      tbl.push_back('{1'b1, 32'h020, 32'hDEADBEEF, 4'hF, 32'h0,        8'h00});
      tbl.push_back('{1'b0, 32'h000, 32'h0,        4'h0, 32'h12345678, 8'h00});
      tbl.push_back('{1'b1, 32'h01E, 32'h77665544, 4'hF, 32'h77665544, 8'h80});
      tbl.push_back('{1'b0, 32'h01D, 32'h0,        4'h0, 32'h77665544, 8'h00});
      tbl.push_back('{1'b1, 32'h008, 32'hFFFFFFFF, 4'h0, 32'h00000000, 8'h04});
      tbl.push_back('{1'b0, 32'h008, 32'h0,        4'h0, 32'h00000000, 8'h00});
      tbl.push_back('{1'b1, 32'h1004, 32'h0BADF00D, 4'hF, 32'h0BADF00D, 8'h02});
      tbl.push_back('{1'b0, 32'hF004, 32'h0,       4'h0, 32'h0BADF00D, 8'h00});

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_awready", 32'(bif.s_axi_awready), 32'd1);
      check("rst_wready",  32'(bif.s_axi_wready),  32'd1);
      check("rst_arready", 32'(bif.s_axi_arready), 32'd1);
      check("rst_bvalid",  32'(bif.s_axi_bvalid),  32'd0);
      check("rst_rvalid",  32'(bif.s_axi_rvalid),  32'd0);
      check("rst_rdata",   bif.s_axi_rdata,        32'd0);
      check("rst_reg_wr",  32'(reg_wr),            32'd0);
      check("rst_reg_q",   32'(reg_q != '0),       32'd0);
      @(posedge aclk);
      #1;
      areset = 1'b0;
      #1;
      check("rel_awready", 32'(bif.s_axi_awready), 32'd1);
      check("rel_arready", 32'(bif.s_axi_arready), 32'd1);
      @(posedge aclk);
      #1;

      foreach (tbl[i]) begin
         if (tbl[i].is_wr) begin
            axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, 0, tbl[i].exp_wr);
            if (tbl[i].exp_wr != 8'h00) begin
               idx = int'(tbl[i].addr[4:2]);
               check($sformatf("vec%0d_reg_q", i), reg_q[idx*32 +: 32], tbl[i].exp);
            end
         end else begin
            axi_read(tbl[i].addr, 0, 0, rd);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
         end
      end

      // AW two cycles ahead of W
      axi_write(32'h00C, 32'hCAFE0003, 4'hF, 0, 2, 0, 8'h08);
      axi_read(32'h00C, 0, 0, rd);
      check("aw_first_rdata", rd, 32'hCAFE0003);

      // W ahead of AW, then bready held off for four bvalid cycles
      axi_write(32'h010, 32'h01010101, 4'hF, 3, 0, 0, 8'h10);
      axi_write(32'h014, 32'h00000002, 4'hF, 0, 0, 6, 8'h20);
      axi_read(32'h010, 0, 0, rd);
      check("w_first_rdata", rd, 32'h01010101);
      axi_read(32'h014, 0, 3, rd);
      check("b_stall_rdata", rd, 32'h00000002);

      // read capture and write commit to offset 0x8 on one edge
      axi_write(32'h008, 32'h00000001, 4'hF, 0, 0, 0, 8'h04);
      fork
         axi_write(32'h008, 32'h00000002, 4'hF, 0, 0, 0, 8'h04);
         axi_read(32'h008, 1, 0, rd);
      join
      check("collide_old", rd, 32'h00000001);
      axi_read(32'h008, 0, 0, rd);
      check("collide_new", rd, 32'h00000002);

      // reset while a B response is pending
      bif.s_axi_awaddr = 32'h018; bif.s_axi_wdata = 32'h00000055; bif.s_axi_wstrb = 4'hF;
      bif.s_axi_awvalid = 1'b1; bif.s_axi_wvalid = 1'b1; bif.s_axi_bready = 1'b0;
      @(posedge aclk);
      #1;
      bif.s_axi_awvalid = 1'b0; bif.s_axi_wvalid = 1'b0;
      for (int i = 0; i < 10 && !bif.s_axi_bvalid; i++) begin
         @(posedge aclk);
         #1;
      end
      check("rst_mid_bvalid_pend", 32'(bif.s_axi_bvalid), 32'd1);
      check("rst_mid_reg_q_pend", 32'(reg_q != '0), 32'd1);
      areset = 1'b1;
      #1;
      check("rst_mid_bvalid", 32'(bif.s_axi_bvalid), 32'd0);
      check("rst_mid_reg_q",  32'(reg_q != '0),      32'd0);
      @(posedge aclk);
      #1;
      areset = 1'b0;
      #1;
      check("rst_mid_rdy", {30'd0, bif.s_axi_awready, bif.s_axi_wready}, 32'd3);
      @(posedge aclk);
      #1;
      axi_read(32'h018, 0, 0, rd);
      check("rst_mid_cleared", rd, 32'h00000000);
      axi_write(32'h018, 32'h00000055, 4'hF, 0, 0, 0, 8'h40);
      axi_read(32'h018, 0, 0, rd);
      check("rst_mid_reissue", rd, 32'h00000055);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
